ysyx_24100006_mem_arbiter: RTL and testbench
============================================

# ysyx_24100006_mem_arbiter

Shares the single data/instruction memory port of the `ysyx_24100006` core between two requesters: the instruction fetch path (IFU) and the load/store path (LSU). It accepts one request at a time, holds it on a valid/ready request channel to memory, waits for the memory response, and returns a one-cycle response pulse to the owning requester. It sits between the PC/fetch logic and the LSU on one side and the memory on the other. It is the first step from the single-cycle datapath towards a multi-cycle core with a real bus.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `ifu_req_valid`  in  1  IFU requests a read at `ifu_addr`
- `ifu_req_ready`  out  1  IFU request accepted this cycle
- `ifu_addr`  in  ADDR_W  fetch address
- `ifu_resp_valid`  out  1  one-cycle pulse; `ifu_rdata` valid
- `ifu_rdata`  out  DATA_W  fetched instruction
- `lsu_req_valid`  in  1  LSU request
- `lsu_req_ready`  out  1  LSU request accepted this cycle
- `lsu_addr`  in  ADDR_W  load/store address
- `lsu_wen`  in  1  1 = store, 0 = load
- `lsu_wdata`  in  DATA_W  store data
- `lsu_wmask`  in  8  store byte mask
- `lsu_resp_valid`  out  1  one-cycle pulse; load data valid or store done
- `lsu_rdata`  out  DATA_W  load data
- `mem_req_valid`  out  1  request to memory
- `mem_req_ready`  in  1  memory accepts the request
- `mem_addr`  out  ADDR_W  latched address
- `mem_wen`  out  1  latched write enable; 0 for IFU
- `mem_wdata`  out  DATA_W  latched store data
- `mem_wmask`  out  8  latched mask; 0 for IFU
- `mem_resp_valid`  in  1  memory response
- `mem_rdata`  in  DATA_W  memory read data

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- **IDLE**
  - Arbitration is combinational. At most one of `ifu_req_ready`/`lsu_req_ready` is high, and only for a requester whose valid is high.
  - On a handshake (valid and ready both high at the edge):
    - latch addr, wen, wdata, wmask and the owner bit;
    - force wen and wmask to 0 for the IFU;
    - go to ISSUE.
- **ISSUE**
  - `mem_req_valid` is 1 and the `mem_*` fields hold the latched values, stable until `mem_req_ready`.
  - On `mem_req_ready` go to WAIT.
- **WAIT**
  - On `mem_resp_valid`, latch `mem_rdata` and go to RESP.
- **RESP**
  - Pulse the owner's `*_resp_valid` for exactly one cycle.
  - Go to IDLE.
  - No new request is accepted in RESP.
- Stores also receive a response. `lsu_rdata` then carries whatever `mem_rdata` held.
- `ifu_rdata` and `lsu_rdata` are driven from one shared data register. Each is valid only while its own resp_valid is high and holds its value otherwise.
- `mem_resp_valid` outside WAIT is ignored.
- A requester may drop valid without being granted. Nothing is latched in that case.
- Requesters have no resp_ready: they must accept the response pulse.
- Default arbitration (macro absent): fixed LSU priority. When both requesters are valid in IDLE, the LSU wins.

## Timing
- Reset values:
  - state IDLE;
  - all `*_ready`, `*_resp_valid` and `mem_req_valid` low;
  - `mem_addr`, `mem_wdata`, `mem_wmask`, `mem_wen` and the data register 0;
  - last-grant register = IFU.
- Accept at edge T0. `mem_req_valid` is high in cycle T0+1.
- With `mem_req_ready` high in T0+1 and `mem_resp_valid` high in T0+2, resp_valid is high in T0+3.
  - This is the minimum latency: 3 cycles from accept to response.
  - Next accept possible at T0+4.
- Each stall cycle of `mem_req_ready` or `mem_resp_valid` adds exactly one cycle. There is no timeout.
- Reset mid-transaction (any state):
  - the transaction is abandoned;
  - no resp_valid is emitted;
  - a later `mem_resp_valid` in IDLE is ignored.
- Only one transaction is ever outstanding.

## Configuration
- `YSYX_24100006_ARB_RR_EN`
  - Defined: round-robin arbitration. A one-bit last-grant register, reset to IFU, is updated on every accept. On contention the requester not granted last wins, so the first contention after reset goes to the LSU. Without contention the sole requester always wins.
  - Undefined: fixed LSU priority, and no last-grant register is built.

## Test plan
- IFU-only read: `ifu_addr`=0x80000000, memory returns 0x00000413 with zero stalls -> `ifu_resp_valid` pulses 3 cycles after accept, `ifu_rdata`=0x00000413, `mem_wen`=0, `mem_wmask`=0.
- LSU store: addr 0x80001000, wdata 0xDEADBEEF, wmask 0x0F, `mem_req_ready` held low 2 cycles -> `mem_*` fields stable for all 3 ISSUE cycles, `lsu_resp_valid` pulses 5 cycles after accept, `ifu_resp_valid` stays 0.
- Contention, macro undefined: both valid continuously for 3 transactions -> LSU granted all 3 times, IFU never ready.
- Contention, macro defined: both valid continuously -> grants LSU, IFU, LSU, IFU.
- Reset in WAIT: assert `reset` for one cycle, then pulse `mem_resp_valid` -> no resp_valid on either port, state IDLE, next IFU request is accepted normally.
- Stray `mem_resp_valid` in IDLE and ISSUE -> no response pulse; data register unchanged.

Source files
------------

// File: rtl/ysyx_24100006_mem_arbiter.sv
// ysyx_24100006_mem_arbiter
// Shares the single memory port of the core between the instruction fetch
// path (IFU) and the load/store path (LSU). One request is accepted at a
// time, held on a valid/ready channel to memory until accepted, and the
// memory response is returned as a one-cycle pulse to the owning requester.
//
// Optional feature macro: YSYX_24100006_ARB_RR_EN
//   defined   -> round-robin arbitration using a one-bit last-grant register
//   undefined -> fixed LSU priority, no last-grant register
module ysyx_24100006_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_resp_valid,
    output logic [DATA_W-1:0] ifu_rdata,

    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic              lsu_wen,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [7:0]        lsu_wmask,
    output logic              lsu_resp_valid,
    output logic [DATA_W-1:0] lsu_rdata,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [7:0]        mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic              grant_ifu;
    logic              grant_lsu;
    logic              owner_lsu;
    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic [7:0]        wmask_q;
    logic [DATA_W-1:0] rdata_q;

`ifdef YSYX_24100006_ARB_RR_EN
    logic last_lsu;

    // Round-robin grant: on contention the requester not served last wins
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (state == IDLE && !reset) begin
            if (ifu_req_valid && lsu_req_valid) begin
                grant_lsu = ~last_lsu;
                grant_ifu = last_lsu;
            end else begin
                grant_lsu = lsu_req_valid;
                grant_ifu = ifu_req_valid;
            end
        end
    end

    // Remember who was granted on every accept; reset points at the IFU
    always_ff @(posedge clk) begin
        if (reset) begin
            last_lsu <= 1'b0;
        end else if (grant_ifu || grant_lsu) begin
            last_lsu <= grant_lsu;
        end
    end
`else
    // Fixed-priority grant: the LSU always beats the IFU on contention
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (state == IDLE && !reset) begin
            grant_lsu = lsu_req_valid;
            grant_ifu = ifu_req_valid && !lsu_req_valid;
        end
    end
`endif

    assign ifu_req_ready = grant_ifu;
    assign lsu_req_ready = grant_lsu;

    // Transaction state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus the request valid and response pulses
    always_comb begin
        state_next     = state;
        mem_req_valid  = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (grant_ifu || grant_lsu) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                ifu_resp_valid = ~owner_lsu;
                lsu_resp_valid = owner_lsu;
                state_next     = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture the winning request; fetches never write, so wen/mask/data are cleared
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_lsu <= 1'b0;
            addr_q    <= '0;
            wen_q     <= 1'b0;
            wdata_q   <= '0;
            wmask_q   <= '0;
        end else if (grant_lsu) begin
            owner_lsu <= 1'b1;
            addr_q    <= lsu_addr;
            wen_q     <= lsu_wen;
            wdata_q   <= lsu_wdata;
            wmask_q   <= lsu_wmask;
        end else if (grant_ifu) begin
            owner_lsu <= 1'b0;
            addr_q    <= ifu_addr;
            wen_q     <= 1'b0;
            wdata_q   <= '0;
            wmask_q   <= '0;
        end
    end

    // Shared read-data register, loaded only by a response that arrives in WAIT
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (state == WAIT && mem_resp_valid) begin
            rdata_q <= mem_rdata;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wen   = wen_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;
    assign ifu_rdata = rdata_q;
    assign lsu_rdata = rdata_q;

endmodule

// File: tb/tb_ysyx_24100006_mem_arbiter.sv
// Testbench for ysyx_24100006_mem_arbiter.
// Requests are issued from a stimulus process that predicts the grant and
// pushes the expected memory request and response into queues; a memory
// model serves requests with chosen stall counts, and a monitor compares
// every response pulse and the shared data register against the queue.
module tb_ysyx_24100006_mem_arbiter;

    typedef struct {
        bit          ifuV;
        bit          lsuV;
        logic [31:0] ifuAddr;
        logic [31:0] lsuAddr;
        bit          wen;
        logic [31:0] wdata;
        logic [7:0]  wmask;
        int          s1;
        int          s2;
        logic [31:0] data;
        int          rstAt;
    } stim_t;

    typedef struct {
        bit          isLsu;
        logic [31:0] addr;
        bit          wen;
        logic [31:0] wdata;
        logic [7:0]  wmask;
        int          s1;
        int          s2;
        logic [31:0] data;
        int          acc;
    } req_t;

    typedef struct {
        bit          isLsu;
        logic [31:0] data;
        int          cyc;
    } resp_t;

    logic        clk;
    logic        reset;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_resp_valid;
    logic [31:0] ifu_rdata;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic [31:0] lsu_addr;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [7:0]  lsu_wmask;
    logic        lsu_resp_valid;
    logic [31:0] lsu_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;

    int    cyc = 0;
    int    idleFrom = 0;
    int    checks = 0;
    int    failures = 0;
    bit    lastLsu = 1'b0;
    req_t  reqQ[$];
    resp_t respQ[$];
    logic [31:0] lastData = 32'h0;

    ysyx_24100006_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_addr       (ifu_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_rdata      (ifu_rdata),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_addr       (lsu_addr),
        .lsu_wen        (lsu_wen),
        .lsu_wdata      (lsu_wdata),
        .lsu_wmask      (lsu_wmask),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_rdata      (lsu_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_wen        (mem_wen),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata)
    );

    // Free-running clock and a cycle counter advanced on each rising edge
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Arbitration rule: a sole requester wins; on contention the LSU wins,
    // or under round-robin whoever was not granted last
    function automatic bit pickLsu(input bit ifuV, input bit lsuV);
        if (ifuV && lsuV) begin
`ifdef YSYX_24100006_ARB_RR_EN
            return !lastLsu;
`else
            return 1'b1;
`endif
        end
        return lsuV;
    endfunction

    function automatic stim_t mk(input bit iv, input bit lv, input logic [31:0] ia, input logic [31:0] la,
                                 input bit w, input logic [31:0] wd, input logic [7:0] wm,
                                 input int s1, input int s2, input logic [31:0] d, input int rst);
        stim_t s;
        s.ifuV = iv; s.lsuV = lv; s.ifuAddr = ia; s.lsuAddr = la;
        s.wen = w; s.wdata = wd; s.wmask = wm;
        s.s1 = s1; s.s2 = s2; s.data = d; s.rstAt = rst;
        return s;
    endfunction

    function automatic stim_t randStim();
        int sel;
        int rst;
        sel = $urandom_range(0, 2);
        rst = ($urandom_range(0, 11) == 0) ? $urandom_range(1, 2) : 0;
        return mk(sel != 1, sel != 0, $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
                  $urandom_range(0, 1) == 1, $urandom, 8'($urandom_range(0, 255)),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom, rst);
    endfunction

    // Drive one request, confirm the predicted grant, push the expected
    // memory request and response, then ride out the transaction
    task automatic applyStimulus(input stim_t s);
        bit   wantLsu;
        bit   accepted;
        int   acc;
        req_t r;
        accepted = 1'b0;
        ifu_req_valid = s.ifuV;
        lsu_req_valid = s.lsuV;
        ifu_addr      = s.ifuAddr;
        lsu_addr      = s.lsuAddr;
        lsu_wen       = s.wen;
        lsu_wdata     = s.wdata;
        lsu_wmask     = s.wmask;
        wantLsu       = pickLsu(s.ifuV, s.lsuV);
        for (int k = 0; k < 20 && !accepted; k++) begin
            #1;
            if (cyc >= idleFrom) begin
                checkOutput("ifu_req_ready_grant", 32'(ifu_req_ready), 32'(!wantLsu));
                checkOutput("lsu_req_ready_grant", 32'(lsu_req_ready), 32'(wantLsu));
                accepted = 1'b1;
            end else begin
                checkOutput("ifu_req_ready_busy", 32'(ifu_req_ready), 32'd0);
                checkOutput("lsu_req_ready_busy", 32'(lsu_req_ready), 32'd0);
                @(negedge clk);
                #1;
            end
        end
        if (!accepted) begin
            checkOutput("grant_timeout", 32'd1, 32'd0);
            return;
        end
        acc       = cyc;
        lastLsu   = wantLsu;
        r.isLsu   = wantLsu;
        r.addr    = wantLsu ? s.lsuAddr : s.ifuAddr;
        r.wen     = wantLsu ? s.wen : 1'b0;
        r.wdata   = s.wdata;
        r.wmask   = wantLsu ? s.wmask : 8'h00;
        r.s1      = s.s1;
        r.s2      = s.s2;
        r.data    = s.data;
        r.acc     = acc;
        reqQ.push_back(r);
        respQ.push_back('{wantLsu, s.data, acc + 3 + s.s1 + s.s2});
        idleFrom = acc + 4 + s.s1 + s.s2;
        while (cyc < idleFrom - 1) begin
            @(negedge clk);
            #1;
            if (s.rstAt != 0 && cyc == acc + s.rstAt) begin
                reset = 1'b1;
                ifu_req_valid = 1'b0;
                lsu_req_valid = 1'b0;
                @(negedge clk);
                #1;
                reset = 1'b0;
                lastLsu = 1'b0;
                idleFrom = cyc + 1;
                @(negedge clk);
                #1;
                return;
            end
            if (cyc < idleFrom - 1) begin
                ifu_req_valid = ($urandom_range(0, 1) == 1);
                lsu_req_valid = ($urandom_range(0, 1) == 1);
                ifu_addr      = $urandom;
                lsu_addr      = $urandom;
                #1;
                checkOutput("ifu_req_ready_inflight", 32'(ifu_req_ready), 32'd0);
                checkOutput("lsu_req_ready_inflight", 32'(lsu_req_ready), 32'd0);
            end
        end
    endtask

    // Memory model: serve each request after its chosen stalls, checking
    // the request fields every ISSUE cycle and injecting stray responses
    initial begin : memModel
        int   phase;
        int   stall;
        int   wcnt;
        req_t cur;
        phase = 0; stall = 0; wcnt = 0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (reset) begin
                phase = 0;
                reqQ.delete();
                mem_req_ready  = 1'b0;
                mem_resp_valid = 1'b1;
                mem_rdata      = $urandom;
                continue;
            end
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            mem_rdata      = $urandom;
            if (phase == 0) begin
                if (mem_req_valid) begin
                    if (reqQ.size() == 0) begin
                        checkOutput("unexpected_mem_req", 32'(mem_req_valid), 32'd0);
                    end else begin
                        cur = reqQ.pop_front();
                        checkOutput("issue_cycle", 32'(cyc), 32'(cur.acc + 1));
                        stall = cur.s1;
                        phase = 1;
                    end
                end else begin
                    mem_req_ready  = ($urandom_range(0, 1) == 1);
                    mem_resp_valid = ($urandom_range(0, 2) == 0);
                end
            end else if (phase == 2) begin
                checkOutput("mem_req_valid_wait", 32'(mem_req_valid), 32'd0);
                mem_req_ready = ($urandom_range(0, 1) == 1);
                if (wcnt == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_rdata      = cur.data;
                    phase          = 0;
                end else begin
                    wcnt--;
                end
            end
            if (phase == 1) begin
                checkOutput("mem_req_valid_issue", 32'(mem_req_valid), 32'd1);
                checkOutput("mem_addr", mem_addr, cur.addr);
                checkOutput("mem_wen", 32'(mem_wen), 32'(cur.wen));
                checkOutput("mem_wmask", 32'(mem_wmask), 32'(cur.wmask));
                if (cur.isLsu) begin
                    checkOutput("mem_wdata", mem_wdata, cur.wdata);
                end
                if (stall == 0) begin
                    mem_req_ready = 1'b1;
                    wcnt          = cur.s2;
                    phase         = 2;
                end else begin
                    stall--;
                    mem_resp_valid = 1'b1;
                end
            end
        end
    end

    // Monitor: every response pulse must match the scoreboard head in
    // owner, data and cycle; the shared data register must hold otherwise
    initial begin : monitor
        resp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                respQ.delete();
                lastData = 32'h0;
                checkOutput("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
                checkOutput("rst_ready", 32'({ifu_req_ready, lsu_req_ready}), 32'd0);
                checkOutput("rst_resp_valid", 32'({ifu_resp_valid, lsu_resp_valid}), 32'd0);
                checkOutput("rst_mem_addr", mem_addr, 32'h0);
                checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
                checkOutput("rst_mem_wmask_wen", 32'({mem_wmask, mem_wen}), 32'd0);
            end else begin
                while (respQ.size() > 0 && respQ[0].cyc < cyc) begin
                    e = respQ.pop_front();
                    checkOutput("resp_missing", 32'(e.cyc), 32'(cyc));
                end
                if (respQ.size() > 0 && respQ[0].cyc == cyc) begin
                    e = respQ.pop_front();
                    checkOutput("ifu_resp_valid", 32'(ifu_resp_valid), 32'(!e.isLsu));
                    checkOutput("lsu_resp_valid", 32'(lsu_resp_valid), 32'(e.isLsu));
                    lastData = e.data;
                end else begin
                    checkOutput("spurious_resp", 32'({ifu_resp_valid, lsu_resp_valid}), 32'd0);
                end
            end
            checkOutput("ifu_rdata", ifu_rdata, lastData);
            checkOutput("lsu_rdata", lsu_rdata, lastData);
        end
    end

    // Main sequence: reset, directed cases, random traffic, drain, summary
    initial begin : stimulus
        stim_t dirQ[$];
        reset = 1'b1;
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        ifu_addr = 32'h0; lsu_addr = 32'h0;
        lsu_wen = 1'b0; lsu_wdata = 32'h0; lsu_wmask = 8'h0;
        repeat (3) @(negedge clk);
        #1;
        reset = 1'b0;
        idleFrom = cyc + 1;
        @(negedge clk);
        #1;

        dirQ.push_back(mk(1, 0, 32'h8000_0000, 32'h0, 0, 32'h0, 8'h00, 0, 0, 32'h0000_0413, 0));
        dirQ.push_back(mk(0, 1, 32'h0, 32'h8000_1000, 1, 32'hDEAD_BEEF, 8'h0F, 2, 0, 32'h1234_5678, 0));
        for (int i = 0; i < 4; i++) begin
            dirQ.push_back(mk(1, 1, 32'h8000_0100 + 32'(4 * i), 32'h8000_2000 + 32'(4 * i),
                              i[0], 32'hA5A5_0000 + 32'(i), 8'hFF, i % 2, 1, 32'hC0DE_0000 + 32'(i), 0));
        end
        dirQ.push_back(mk(1, 0, 32'h8000_0040, 32'h0, 0, 32'h0, 8'h00, 0, 5, 32'hBAD0_BAD0, 2));
        dirQ.push_back(mk(1, 0, 32'h8000_0044, 32'h0, 0, 32'h0, 8'h00, 0, 0, 32'h0000_0513, 0));
        foreach (dirQ[i]) applyStimulus(dirQ[i]);

        for (int n = 0; n < 60; n++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                ifu_req_valid = 1'b0;
                lsu_req_valid = 1'b0;
                #1;
                checkOutput("ready_without_valid", 32'({ifu_req_ready, lsu_req_ready}), 32'd0);
                @(negedge clk);
                #1;
            end
            applyStimulus(randStim());
        end

        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checkOutput("resp_queue_drained", 32'(respQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a hung run
    initial begin : watchdog
        #200000;
        failures++;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
